priority_encoder_bidir: RTL and testbench

Parameterised priority encoder. It reports the index of the most-significant set bit of an input vector and, optionally, the index of the least-significant set bit, plus a valid flag. Its primary user is the rename stage, which drives the physical-register free-pool bit-vector into it to pick the next free tag in the same cycle. An optional output register stage allows use on timing-critical paths.

---
 rtl/priority_encoder_bidir_pkg.sv | 21 ++
 rtl/priority_encoder_bidir_if.sv | 29 ++
 rtl/priority_encoder_bidir_tree.sv | 72 +++++++
 rtl/priority_encoder_bidir.sv | 89 ++++++++
 tb/tb_priority_encoder_bidir.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/priority_encoder_bidir_pkg.sv
// Shared types and constant helpers for the bidirectional priority encoder.
package priority_encoder_bidir_pkg;

  typedef enum logic {
    DIR_MSB = 1'b0,
    DIR_LSB = 1'b1
  } search_dir_e;

  // Ceiling log2 for elaboration-time sizing; any WIDTH >= 2 is accepted.
  function automatic int pe_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_bidir_if.sv
// Request vector and encoded results exchanged with the priority encoder.
interface priority_encoder_bidir_if
  import priority_encoder_bidir_pkg::*;
#(
  parameter int WIDTH = 64
) ();

  localparam int IDX_W = pe_clog2(WIDTH);

  logic [WIDTH-1:0] in;
  logic [IDX_W-1:0] out_MSB;
  logic [IDX_W-1:0] out_LSB;
  logic             valid;

  modport master (
    output in,
    input  out_MSB,
    input  out_LSB,
    input  valid
  );

  modport slave (
    input  in,
    output out_MSB,
    output out_LSB,
    output valid
  );

endinterface

// File: rtl/priority_encoder_bidir_tree.sv
// Recursive binary search tree over a power-of-two vector; each level prepends
// one index bit, and an all-zero subtree always reports index 0.
module priority_encoder_bidir_tree
  import priority_encoder_bidir_pkg::*;
#(
  parameter int          WIDTH = 64,
  parameter search_dir_e DIR   = DIR_MSB,
  localparam int         IW    = pe_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [IW-1:0]    index,
  output logic             valid
);

  generate
    if (WIDTH == 2) begin : g_leaf
      // Two-bit leaf: picks the preferred side, 0 when both bits are clear.
      always_comb begin
        valid = in[1] | in[0];
        if (DIR == DIR_MSB) begin
          index = in[1];
        end else begin
          index = ~in[0] & in[1];
        end
      end
    end else begin : g_node
      localparam int HALF = WIDTH / 2;

      logic [IW-2:0] lo_idx_s;
      logic [IW-2:0] hi_idx_s;
      logic          lo_v_s;
      logic          hi_v_s;

      priority_encoder_bidir_tree #(
        .WIDTH (HALF),
        .DIR   (DIR)
      ) u_lo (
        .in    (in[HALF-1:0]),
        .index (lo_idx_s),
        .valid (lo_v_s)
      );

      priority_encoder_bidir_tree #(
        .WIDTH (HALF),
        .DIR   (DIR)
      ) u_hi (
        .in    (in[WIDTH-1:HALF]),
        .index (hi_idx_s),
        .valid (hi_v_s)
      );

      // Merge children; the LSB form gates the upper bit so an empty node stays 0.
      always_comb begin
        valid = lo_v_s | hi_v_s;
        if (DIR == DIR_MSB) begin
          if (hi_v_s) begin
            index = {1'b1, hi_idx_s};
          end else begin
            index = {1'b0, lo_idx_s};
          end
        end else begin
          if (lo_v_s) begin
            index = {1'b0, lo_idx_s};
          end else begin
            index = {hi_v_s, hi_idx_s};
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/priority_encoder_bidir.sv
// Priority encoder reporting highest and (optionally) lowest set bit index of a
// request vector, with an optional registered output stage.
module priority_encoder_bidir
  import priority_encoder_bidir_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int TWO_SIDE = 0,
  parameter int PIPE     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  priority_encoder_bidir_if.slave  bus
);

  localparam int IDX_W = pe_clog2(WIDTH);
  localparam int P     = 32'sd1 <<< IDX_W;

  logic [P-1:0]     in_pad_s;
  logic [IDX_W-1:0] msb_idx_s;
  logic [IDX_W-1:0] lsb_idx_s;
  logic             msb_v_s;
  logic             lsb_v_s;
  logic             res_v_s;

  // Zero-pad to the tree width; padded zeros can never be selected.
  always_comb begin
    in_pad_s            = '0;
    in_pad_s[WIDTH-1:0] = bus.in;
  end

  priority_encoder_bidir_tree #(
    .WIDTH (P),
    .DIR   (DIR_MSB)
  ) u_msb_tree (
    .in    (in_pad_s),
    .index (msb_idx_s),
    .valid (msb_v_s)
  );

  generate
    if (TWO_SIDE != 0) begin : g_lsb
      priority_encoder_bidir_tree #(
        .WIDTH (P),
        .DIR   (DIR_LSB)
      ) u_lsb_tree (
        .in    (in_pad_s),
        .index (lsb_idx_s),
        .valid (lsb_v_s)
      );
    end else begin : g_no_lsb
      assign lsb_idx_s = '0;
      assign lsb_v_s   = 1'b0;
    end
  endgenerate

  assign res_v_s = msb_v_s | lsb_v_s;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [IDX_W-1:0] msb_r;
      logic [IDX_W-1:0] lsb_r;
      logic             valid_r;

      // Output stage reloads every cycle; rst discards the value sampled that edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          msb_r   <= '0;
          lsb_r   <= '0;
          valid_r <= 1'b0;
        end else begin
          msb_r   <= msb_idx_s;
          lsb_r   <= lsb_idx_s;
          valid_r <= res_v_s;
        end
      end

      assign bus.out_MSB = msb_r;
      assign bus.out_LSB = lsb_r;
      assign bus.valid   = valid_r;
    end else begin : g_comb
      logic unused_s;
      assign unused_s    = clk ^ rst;
      assign bus.out_MSB = msb_idx_s;
      assign bus.out_LSB = lsb_idx_s;
      assign bus.valid   = res_v_s;
    end
  endgenerate

endmodule

// File: tb/tb_priority_encoder_bidir.sv
// Self-checking bench: four encoder configurations against a bit-scan reference.
module tb_priority_encoder_bidir;

  logic clk;
  logic rst;
  int   assert_cnt;
  int   fail_cnt;

  priority_encoder_bidir_if #(.WIDTH(64)) bus_a ();
  priority_encoder_bidir_if #(.WIDTH(40)) bus_b ();
  priority_encoder_bidir_if #(.WIDTH(64)) bus_c ();
  priority_encoder_bidir_if #(.WIDTH(64)) bus_d ();

  priority_encoder_bidir #(.WIDTH(64), .TWO_SIDE(1), .PIPE(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  priority_encoder_bidir #(.WIDTH(40), .TWO_SIDE(1), .PIPE(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  priority_encoder_bidir #(.WIDTH(64), .TWO_SIDE(0), .PIPE(0)) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  priority_encoder_bidir #(.WIDTH(64), .TWO_SIDE(1), .PIPE(1)) u_dut_d (.clk(clk), .rst(rst), .bus(bus_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Reference: scan the lowest w bits for highest/lowest set position.
  function automatic int ref_msb(input logic [63:0] v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int ref_lsb(input logic [63:0] v, input int w);
    int r;
    r = 0;
    for (int i = w - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic ref_any(input logic [63:0] v, input int w);
    int n;
    n = 0;
    for (int i = 0; i < w; i++) if (v[i]) n++;
    return (n > 0);
  endfunction

  function automatic logic [63:0] rand_vec();
    logic [63:0] v;
    case ($urandom_range(3, 0))
      0: v = {$urandom, $urandom};
      1: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      2: v = 64'd1 << $urandom_range(63, 0);
      default: v = {$urandom, $urandom} << $urandom_range(63, 0);
    endcase
    return v;
  endfunction

  task automatic apply_a(input string tag, input logic [63:0] v);
    bus_a.in = v;
    #1;
    check_value({tag, ".msb"}, 64'(bus_a.out_MSB), 64'(ref_msb(v, 64)));
    check_value({tag, ".lsb"}, 64'(bus_a.out_LSB), 64'(ref_lsb(v, 64)));
    check_value({tag, ".valid"}, 64'(bus_a.valid), 64'(ref_any(v, 64)));
  endtask

  task automatic apply_b(input string tag, input logic [63:0] v);
    bus_b.in = v[39:0];
    #1;
    check_value({tag, ".msb"}, 64'(bus_b.out_MSB), 64'(ref_msb(v, 40)));
    check_value({tag, ".lsb"}, 64'(bus_b.out_LSB), 64'(ref_lsb(v, 40)));
    check_value({tag, ".valid"}, 64'(bus_b.valid), 64'(ref_any(v, 40)));
  endtask

  task automatic apply_c(input string tag, input logic [63:0] v);
    bus_c.in = v;
    #1;
    check_value({tag, ".msb"}, 64'(bus_c.out_MSB), 64'(ref_msb(v, 64)));
    check_value({tag, ".lsb"}, 64'(bus_c.out_LSB), 64'd0);
    check_value({tag, ".valid"}, 64'(bus_c.valid), 64'(ref_any(v, 64)));
  endtask

  task automatic pipe_step(input string tag, input logic r, input logic [63:0] v);
    @(negedge clk);
    rst      = r;
    bus_d.in = v;
    @(posedge clk);
    #1;
    check_value({tag, ".msb"}, 64'(bus_d.out_MSB), r ? 64'd0 : 64'(ref_msb(v, 64)));
    check_value({tag, ".lsb"}, 64'(bus_d.out_LSB), r ? 64'd0 : 64'(ref_lsb(v, 64)));
    check_value({tag, ".valid"}, 64'(bus_d.valid), r ? 64'd0 : 64'(ref_any(v, 64)));
  endtask

  initial begin
    logic [63:0] v;
    assert_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    bus_a.in   = '0;
    bus_b.in   = '0;
    bus_c.in   = '0;
    bus_d.in   = 64'h1;

    // Directed cases for the combinational configurations.
    apply_a("a_zero", 64'h0);
    apply_a("a_ends", 64'h8000_0000_0000_0001);
    apply_a("a_pool", 64'hFFFF_FFFF_0000_0000);
    for (int i = 0; i < 64; i++) apply_a("a_walk", 64'd1 << i);
    for (int i = 0; i < 1000; i++) apply_a("a_rand", rand_vec());

    apply_b("b_mid", 64'h00_0001_0000);
    apply_b("b_top", 64'h80_0000_0000);
    apply_b("b_zero", 64'h0);
    for (int i = 0; i < 40; i++) apply_b("b_walk", 64'd1 << i);
    for (int i = 0; i < 300; i++) apply_b("b_rand", rand_vec());

    apply_c("c_nibble", 64'h0000_0000_00F0_0000);
    apply_c("c_zero", 64'h0);
    for (int i = 0; i < 300; i++) apply_c("c_rand", rand_vec());

    // Registered configuration: reset, latency, mid-stream reset, streaming.
    pipe_step("d_rst1", 1'b1, 64'h1);
    pipe_step("d_rst2", 1'b1, 64'h1);
    pipe_step("d_e3", 1'b0, 64'h10);
    @(negedge clk);
    bus_d.in = 64'h0;
    #1;
    check_value("d_hold.valid", 64'(bus_d.valid), 64'd1);
    check_value("d_hold.msb", 64'(bus_d.out_MSB), 64'd4);
    @(posedge clk);
    #1;
    check_value("d_e4.valid", 64'(bus_d.valid), 64'd0);
    check_value("d_e4.msb", 64'(bus_d.out_MSB), 64'd0);
    pipe_step("d_e5", 1'b0, 64'h0000_0000_0000_00F0);
    pipe_step("d_e6rst", 1'b1, 64'h1);
    pipe_step("d_after", 1'b0, 64'h8000_0000_0000_0000);
    for (int i = 0; i < 200; i++) begin
      v = rand_vec();
      pipe_step("d_stream", 1'b0, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
